memory_loader: RTL
==================

MEMORY_LOADER -- requirements
Module: memory_loader

Interface
REQ-001 Parameter: BASE_ADDR, 12'h000, memory word address written by the first data word of a load.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  one-cycle request to begin a load.
REQ-005 Port: byte_in  input  8  incoming stream byte.
REQ-006 Port: byte_valid  input  1  byte_in valid this cycle.
REQ-007 Port: byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high on a rising edge.
REQ-008 Port: mem_we  output  1  write enable to the memory unit.
REQ-009 Port: mem_address  output  12  memory word address.
REQ-010 Port: mem_write_data  output  16  word to be written.
REQ-011 Port: busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-012 Port: done  output  1  load completed successfully; held until next start or reset.
REQ-013 Port: error  output  1  load aborted; held until next start or reset.
REQ-014 Port: words_loaded  output  13  count of data words written in the current or last load.

Function
REQ-015 Stream format SHALL be: header word N, then N data words, then (with CHECKSUM_EN) one checksum word; every word is sent high byte first.
REQ-016 States SHALL be IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO, DONE, ERROR.
REQ-017 start in IDLE, DONE or ERROR SHALL enter HDR_HI next cycle, clear done, error and words_loaded, and load the address register with BASE_ADDR; start while busy SHALL be ignored.
REQ-018 byte_ready SHALL be high only in HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO; each _HI state advances to its _LO state on a transfer; each _LO state completes the word on a transfer.
REQ-019 On header completion, N in 1..4096 SHALL go to DAT_HI; N=0 or N>4096 SHALL go to ERROR.
REQ-020 On DAT_LO transfer, the assembled word SHALL be registered and the state SHALL go to WRITE.
REQ-021 In WRITE, mem_we SHALL be high for exactly one cycle, with mem_address equal to the address register and mem_write_data equal to the assembled word. The write therefore lands one cycle after the low-byte transfer.
REQ-022 On leaving WRITE: the address SHALL increment modulo 4096 (4095 wraps to 0) and words_loaded SHALL increment. If words_loaded then equals N, the state SHALL go to CHK_HI (CHECKSUM_EN) or DONE; otherwise it SHALL go to DAT_HI.
REQ-023 mem_we SHALL be low in every state other than WRITE. mem_address and mem_write_data SHALL hold their last values outside WRITE.
REQ-024 Peak throughput SHALL be one word per 3 cycles; byte_valid gaps SHALL only stall the state machine.
REQ-025 done and error SHALL be mutually exclusive; DONE and ERROR SHALL remain until start.

Reset
REQ-026 rst SHALL immediately force IDLE, mem_we=0, byte_ready=0, busy=0, done=0, error=0, mem_address=0, mem_write_data=0, words_loaded=0 and checksum accumulator=0, independent of clk.
REQ-027 rst asserted mid-load SHALL abort without completing any pending write; words already written remain in memory.

Configuration
REQ-028 Macro CHECKSUM_EN defined: a 16-bit accumulator SHALL sum all data words modulo 2^16. After CHK_LO, a match with the received checksum word SHALL go to DONE; a mismatch SHALL go to ERROR.
REQ-029 Macro CHECKSUM_EN undefined: CHK_HI, CHK_LO and the accumulator SHALL not exist; after the last WRITE the state SHALL go to DONE directly.

Verification
REQ-030 start; stream 00 02 12 34 AB CD with no gaps (no CHECKSUM_EN) -> mem_we pulses write 0x1234@0x000 and 0xABCD@0x001; done=1; words_loaded=2; busy=0.
REQ-031 With CHECKSUM_EN: stream 00 02 12 34 AB CD BE 01 -> done=1. The same stream with trailer BE 02 -> error=1, done=0, and both words are still written.
REQ-032 BASE_ADDR=12'hFFF, N=2, data 0001 0002 -> writes at 0xFFF then 0x000 (wrap).
REQ-033 Header 00 00 -> error=1, no mem_we pulse. Header 10 01 (4097) -> error=1.
REQ-034 Assert rst for one cycle while in DAT_LO -> mem_we stays 0, state is IDLE, all outputs zero. A following start plus a full stream -> normal load.
REQ-035 Random byte_valid gaps and start pulses during busy -> same memory contents as the no-gap run; start during busy has no effect.

Source files
------------

// File: rtl/memory_loader.sv
// memory_loader: turns a byte stream (header word N, N data words, optional
// checksum word; every word high byte first) into one-cycle memory writes at
// consecutive word addresses starting at BASE_ADDR, wrapping modulo 4096.
// Optional feature macro: CHECKSUM_EN adds a trailing checksum word that is
// compared with the 16-bit sum of all data words.
module memory_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [11:0] mem_address,
    output logic [15:0] mem_write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [12:0] words_loaded
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_HDR_HI = 4'd1;
    localparam logic [3:0] S_HDR_LO = 4'd2;
    localparam logic [3:0] S_DAT_HI = 4'd3;
    localparam logic [3:0] S_DAT_LO = 4'd4;
    localparam logic [3:0] S_WRITE  = 4'd5;
`ifdef CHECKSUM_EN
    localparam logic [3:0] S_CHK_HI = 4'd6;
    localparam logic [3:0] S_CHK_LO = 4'd7;
`endif
    localparam logic [3:0] S_DONE   = 4'd8;
    localparam logic [3:0] S_ERROR  = 4'd9;

    logic [3:0]  state;
    logic [11:0] addr_reg;
    logic [7:0]  hi_byte;
    logic [12:0] n_reg;
    logic [15:0] hdr_word;
    logic [12:0] wl_next;
    logic        xfer;
`ifdef CHECKSUM_EN
    logic [15:0] chk_acc;
`endif

    // A legal load carries between 1 and 4096 data words.
    function automatic logic hdr_ok(input logic [15:0] n);
        return (n != 16'd0) && (n <= 16'd4096);
    endfunction

    // The byte arriving in a _LO state completes the word started by hi_byte.
    assign hdr_word = {hi_byte, byte_in};
    assign wl_next  = words_loaded + 13'd1;
    assign xfer     = byte_valid & byte_ready;

    // Output decode: byte acceptance, write strobe and status follow the state.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO: byte_ready = 1'b1;
`ifdef CHECKSUM_EN
            S_CHK_HI, S_CHK_LO:                     byte_ready = 1'b1;
`endif
            S_WRITE: mem_we = 1'b1;
            S_IDLE:  busy   = 1'b0;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    // Load sequencer: byte assembly, write staging, address and word counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            addr_reg       <= 12'd0;
            hi_byte        <= 8'd0;
            n_reg          <= 13'd0;
            words_loaded   <= 13'd0;
            mem_address    <= 12'd0;
            mem_write_data <= 16'd0;
`ifdef CHECKSUM_EN
            chk_acc        <= 16'd0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_HDR_HI;
                        addr_reg     <= BASE_ADDR;
                        words_loaded <= 13'd0;
`ifdef CHECKSUM_EN
                        chk_acc      <= 16'd0;
`endif
                    end
                end
                S_HDR_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
                        state   <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        if (hdr_ok(hdr_word)) begin
                            n_reg <= hdr_word[12:0];
                            state <= S_DAT_HI;
                        end else begin
                            state <= S_ERROR;
                        end
                    end
                end
                S_DAT_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
                        state   <= S_DAT_LO;
                    end
                end
                S_DAT_LO: begin
                    // Stage the write so address and data are stable for the whole WRITE cycle.
                    if (xfer) begin
                        mem_address    <= addr_reg;
                        mem_write_data <= hdr_word;
                        state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_reg     <= addr_reg + 12'd1;
                    words_loaded <= wl_next;
`ifdef CHECKSUM_EN
                    chk_acc      <= chk_acc + mem_write_data;
                    state        <= (wl_next == n_reg) ? S_CHK_HI : S_DAT_HI;
`else
                    state        <= (wl_next == n_reg) ? S_DONE : S_DAT_HI;
`endif
                end
`ifdef CHECKSUM_EN
                S_CHK_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
                        state   <= S_CHK_LO;
                    end
                end
                S_CHK_LO: begin
                    if (xfer) begin
                        state <= (hdr_word == chk_acc) ? S_DONE : S_ERROR;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
